fetch_queue: RTL and testbench

Instruction prefetch queue between main memory's instruction port and the decode stage of the pipeline. It issues sequential word fetches ahead of decode and buffers the returned instructions with their PCs in a small in-order FIFO. On a taken branch it flushes all buffered and in-flight instructions and restarts fetching at the redirect address. This decouples decode from instruction-memory latency and lets a halted decode stage stall without losing fetched words.

---
 rtl/fetch_queue.sv | 171 +++++++++++++++++
 tb/tb_fetch_queue.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
//------------------------------------------------------------------------------
// Module      : fetch_queue
// Description : Instruction prefetch queue. Issues sequential word fetches,
//               buffers {instr, pc} in an in-order FIFO, and flushes on redirect.
//               Optional macro FQ_BYPASS_EN allows a new request in the same
//               cycle a response returns (one fetch per cycle).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     mem_req,
    output logic [XLEN-1:0]          mem_addr,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [XLEN-1:0]          mem_rdata,
    input  logic                     deq,
    output logic                     out_valid,
    output logic [XLEN-1:0]          out_instr,
    output logic [XLEN-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] C_FULL    = CW'(DEPTH);
    localparam logic [CW-1:0] C_FULL_M1 = CW'(DEPTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]      state_q,    state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] pend_pc_q,  pend_pc_d;
    logic [PW-1:0]   head_q,     head_d;
    logic [PW-1:0]   tail_q,     tail_d;
    logic [CW-1:0]   count_q,    count_d;
    logic [XLEN-1:0] instr_q [DEPTH];
    logic [XLEN-1:0] instr_d [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [XLEN-1:0] pc_d    [DEPTH];

    logic w_gnt_fire;
    logic w_enq;
    logic w_deq;

    assign w_gnt_fire = mem_req & mem_gnt;
    assign w_enq      = mem_rvalid & (state_q == S_WAIT) & ~flush;
    assign w_deq      = deq & out_valid & ~flush;

    assign mem_addr  = fetch_pc_q;
    assign out_valid = (count_q != '0);
    assign out_instr = instr_q[head_q];
    assign out_pc    = pc_q[head_q];
    assign count     = count_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a grant taken together with flush is still in flight
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_gnt_fire) state_d = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (w_gnt_fire)      state_d = flush ? S_DRAIN : S_WAIT;
                else if (mem_rvalid) state_d = S_IDLE;
                else if (flush)      state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (mem_rvalid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic; request is held low while in reset
    always_comb begin
        mem_req = 1'b0;
        if (rst) begin
            case (state_q)
                S_IDLE:  mem_req = (count_q < C_FULL);
`ifdef FQ_BYPASS_EN
                S_WAIT:  mem_req = mem_rvalid & (count_q < C_FULL_M1);
`else
                S_WAIT:  mem_req = 1'b0;
`endif
                default: mem_req = 1'b0;
            endcase
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        instr_d    = instr_q;
        pc_d       = pc_q;

        if (w_gnt_fire) begin
            pend_pc_d  = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end

        if (flush) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (w_enq) begin
                instr_d[tail_q] = mem_rdata;
                pc_d[tail_q]    = pend_pc_q;
                tail_d          = tail_q + PW'(1);
            end
            if (w_deq) begin
                head_d = head_q + PW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
//------------------------------------------------------------------------------
// Module      : tb_fetch_queue
// Description : Directed self-checking bench for fetch_queue with a simple
//               in-order memory model of configurable grant-to-response latency.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        deq;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  count;

    int          vectors;
    int          miscompares;
    int          lat;
    int          resp_cnt;
    logic [31:0] resp_addr;

    fetch_queue #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .deq         (deq),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of the memory model; returns 1 ns after the rising edge
    task automatic cycle();
        logic        g;
        logic [31:0] a;
        mem_gnt    = 1'b1;
        mem_rvalid = (resp_cnt == 1);
        mem_rdata  = 32'h1000_0000 + resp_addr;
        #2;
        g = mem_req & mem_gnt;
        a = mem_addr;
        @(posedge clk);
        #1;
        if (resp_cnt > 0) resp_cnt--;
        if (g) begin
            resp_cnt  = lat;
            resp_addr = a;
        end
        mem_rvalid = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        lat         = 1;
        resp_cnt    = 0;
        resp_addr   = '0;
        rst         = 1'b0;
        flush       = 1'b0;
        redirect_pc = '0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        deq         = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_req",    {31'b0, mem_req},   32'd0);
        check("rst_addr",   mem_addr,           32'h0);
        check("rst_valid",  {31'b0, out_valid}, 32'd0);
        check("rst_instr",  out_instr,          32'h0);
        check("rst_pc",     out_pc,             32'h0);
        check("rst_count",  {29'b0, count},     32'd0);
        rst = 1'b1;
        #1;
        check("rel_req",    {31'b0, mem_req},   32'd1);
        check("rel_addr",   mem_addr,           32'h0);

        // Fill with no dequeue: 4 fetches, 2 cycles each
        repeat (8) cycle();
        check("fill_count", {29'b0, count},     32'd4);
        check("fill_req",   {31'b0, mem_req},   32'd0);
        check("fill_instr", out_instr,          32'h1000_0000);
        check("fill_pc",    out_pc,             32'h0);
        repeat (2) cycle();
        check("full_hold",  {29'b0, count},     32'd4);
        check("full_req",   {31'b0, mem_req},   32'd0);

        // Dequeue while refilling; third deq coincides with a response at count=2
        deq = 1'b1;
        cycle();
        check("deq1_count", {29'b0, count},     32'd3);
        check("deq1_pc",    out_pc,             32'h4);
        check("deq1_instr", out_instr,          32'h1000_0004);
        cycle();
        check("deq2_count", {29'b0, count},     32'd2);
        check("deq2_pc",    out_pc,             32'h8);
        cycle();
        check("enqdeq_cnt", {29'b0, count},     32'd2);
        check("enqdeq_pc",  out_pc,             32'hC);
        deq = 1'b0;

        // Flush while a slow request is outstanding
        lat = 3;
        cycle();
        check("wait_req",   {31'b0, mem_req},   32'd0);
        flush       = 1'b1;
        redirect_pc = 32'h203;
        cycle();
        flush = 1'b0;
        check("fl_count",   {29'b0, count},     32'd0);
        check("fl_valid",   {31'b0, out_valid}, 32'd0);
        check("fl_drain",   {31'b0, mem_req},   32'd0);
        check("fl_addr",    mem_addr,           32'h200);
        lat = 1;
        repeat (2) cycle();
        check("drop_count", {29'b0, count},     32'd0);
        check("drop_req",   {31'b0, mem_req},   32'd1);
        check("drop_addr",  mem_addr,           32'h200);
        repeat (2) cycle();
        check("rd_valid",   {31'b0, out_valid}, 32'd1);
        check("rd_pc",      out_pc,             32'h200);
        check("rd_instr",   out_instr,          32'h1000_0200);
        check("rd_count",   {29'b0, count},     32'd1);

        // Redirect near the top of the address space; flush coincides with a grant
        flush       = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cycle();
        flush = 1'b0;
        check("wr_count",   {29'b0, count},     32'd0);
        check("wr_drain",   {31'b0, mem_req},   32'd0);
        check("wr_addr0",   mem_addr,           32'hFFFF_FFFC);
        cycle();
        check("wr_req",     {31'b0, mem_req},   32'd1);
        check("wr_addr1",   mem_addr,           32'hFFFF_FFFC);
        cycle();
        check("wr_wrap",    mem_addr,           32'h0);
        cycle();
        check("wr_pc",      out_pc,             32'hFFFF_FFFC);
        check("wr_instr",   out_instr,          32'h0FFF_FFFC);
        check("wr_req2",    {31'b0, mem_req},   32'd1);
        check("wr_addr2",   mem_addr,           32'h0);
        repeat (4) cycle();
        check("mid_count",  {29'b0, count},     32'd3);

        // Asynchronous reset in the middle of a cycle
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid",   {31'b0, out_valid}, 32'd0);
        check("ar_count",   {29'b0, count},     32'd0);
        check("ar_req",     {31'b0, mem_req},   32'd0);
        check("ar_addr",    mem_addr,           32'h0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        resp_cnt = 0;
        #1;
        check("ar_rel_req", {31'b0, mem_req},   32'd1);
        check("ar_rel_adr", mem_addr,           32'h0);
        repeat (2) cycle();
        check("ar_pc",      out_pc,             32'h0);
        check("ar_instr",   out_instr,          32'h1000_0000);
        check("ar_cnt",     {29'b0, count},     32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
